// File: rtl/ifdef_pkg.sv
// ifdef_pkg: shared types for the conditional-compilation stack controller.
//   kind_e  - token kinds carried on in_kind
//   err_e   - sticky error causes reported on err_code
//   entry_t - one nesting level: {parent, taken, in_else}
//   state_e - controller run / error state
package ifdef_pkg;

  typedef enum logic [2:0] {
    K_TEXT   = 3'd0,
    K_IFDEF  = 3'd1,
    K_IFNDEF = 3'd2,
    K_ELSIF  = 3'd3,
    K_ELSE   = 3'd4,
    K_ENDIF  = 3'd5,
    K_DEFINE = 3'd6,
    K_UNDEF  = 3'd7
  } kind_e;

  typedef enum logic [2:0] {
    ERR_NONE         = 3'd0,
    ERR_OVERFLOW     = 3'd1,
    ERR_UNDERFLOW    = 3'd2,
    ERR_ELSE_ORDER   = 3'd3,
    ERR_UNTERMINATED = 3'd4
  } err_e;

  // parent : enclosing region was emitting when this level opened
  // taken  : some branch of this level has already been emitted
  // in_else: the ELSE branch of this level has been entered
  typedef struct packed {
    logic parent;
    logic taken;
    logic in_else;
  } entry_t;

  typedef enum logic [0:0] {
    ST_RUN = 1'b0,
    ST_ERR = 1'b1
  } state_e;

endpackage

// File: rtl/ifdef_stack_ctrl_cond_stack.sv
// cond_stack: registered LIFO of conditional nesting entries.
//   push_i/din_i - push din_i on top (ignored when full)
//   pop_i        - discard top entry (ignored when empty)
//   wr_i/din_i   - overwrite the current top entry (ELSIF/ELSE bookkeeping)
//   top_o        - current top entry, zero when empty
//   count_o      - number of valid entries (nesting depth)
module cond_stack
  import ifdef_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DPW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push_i,
  input  logic           pop_i,
  input  logic           wr_i,
  input  entry_t         din_i,
  output entry_t         top_o,
  output logic [DPW-1:0] count_o
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t         mem_q [DEPTH];
  logic [DPW-1:0] sp_q;
  logic [IW-1:0]  push_idx_s;
  logic [IW-1:0]  top_idx_s;

  assign push_idx_s = IW'(sp_q);
  assign top_idx_s  = IW'(sp_q - DPW'(1));
  assign top_o      = (sp_q != DPW'(0)) ? mem_q[top_idx_s] : '0;
  assign count_o    = sp_q;

  // Stack pointer and entry storage; push, pop and top-rewrite are mutually exclusive.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_i && (sp_q != DPW'(DEPTH))) begin
      mem_q[push_idx_s] <= din_i;
      sp_q              <= sp_q + DPW'(1);
    end else if (pop_i && (sp_q != DPW'(0))) begin
      sp_q <= sp_q - DPW'(1);
    end else if (wr_i && (sp_q != DPW'(0))) begin
      mem_q[top_idx_s] <= din_i;
    end
  end

endmodule

// File: rtl/ifdef_stack_ctrl.sv
// ifdef_stack_ctrl: streaming #ifdef/#else/#endif evaluator.
//   in_*      - token stream (kind, symbol, payload, last), valid/ready handshake
//   out_*     - forwarded TEXT payloads of emitting regions, valid/ready handshake
//   depth     - current conditional nesting depth
//   active    - current region is emitting
//   done      - one-cycle pulse after a cleanly terminated stream
//   err       - sticky error flag, err_code holds the first cause
module ifdef_stack_ctrl
  import ifdef_pkg::*;
#(
  parameter int                  DEPTH    = 8,
  parameter int                  SYMW     = 4,
  parameter int                  DW       = 32,
  parameter logic [2**SYMW-1:0]  DEF_INIT = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_kind,
  input  logic [SYMW-1:0]            in_sym,
  input  logic [DW-1:0]              in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DW-1:0]              out_data,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       active,
  output logic                       done,
  output logic                       err,
  output logic [2:0]                 err_code
);

  localparam int DPW = $clog2(DEPTH + 1);

  state_e             state_q, state_d;
  logic               active_q, active_d;
  logic [2**SYMW-1:0] def_q, def_d;
  logic               out_valid_q, out_valid_d;
  logic [DW-1:0]      out_data_q, out_data_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  err_e               err_code_q, err_code_d;

  logic               accept_s;
  logic               push_s, pop_s, wr_s;
  entry_t             din_s, top_s;
  logic [DPW-1:0]     depth_s, post_depth_s;
  logic               err_hit_s;
  err_e               err_cause_s;
  logic               cond_s;

  cond_stack #(.DEPTH(DEPTH), .DPW(DPW)) u_stack (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push_s),
    .pop_i  (pop_s),
    .wr_i   (wr_s),
    .din_i  (din_s),
    .top_o  (top_s),
    .count_o(depth_s)
  );

  // In ERR everything is swallowed; in RUN a token waits only for a free output slot.
  assign in_ready  = (state_q == ST_ERR) ? 1'b1 : (!out_valid_q || out_ready);
  assign accept_s  = in_valid && in_ready;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign depth     = depth_s;
  assign active    = active_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

  // Token decode: directive semantics, error detection and next-state selection.
  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    def_d        = def_q;
    out_valid_d  = out_valid_q && !out_ready;
    out_data_d   = out_data_q;
    done_d       = 1'b0;
    err_d        = err_q;
    err_code_d   = err_code_q;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    wr_s         = 1'b0;
    din_s        = '0;
    post_depth_s = depth_s;
    err_hit_s    = 1'b0;
    err_cause_s  = ERR_NONE;
    cond_s       = 1'b0;

    if ((state_q == ST_RUN) && accept_s) begin
      case (in_kind)
        K_TEXT: begin
          if (active_q) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
          end else begin
            out_data_d  = out_data_q;
          end
        end
        K_IFDEF, K_IFNDEF: begin
          cond_s = active_q && ((in_kind == K_IFDEF) ? def_q[in_sym] : !def_q[in_sym]);
          if (depth_s == DPW'(DEPTH)) begin
            err_hit_s   = 1'b1;
            err_cause_s = ERR_OVERFLOW;
          end else begin
            push_s       = 1'b1;
            din_s        = '{parent: active_q, taken: cond_s, in_else: 1'b0};
            active_d     = cond_s;
            post_depth_s = depth_s + DPW'(1);
          end
        end
        K_ELSIF, K_ELSE: begin
          // ELSIF needs its symbol defined; ELSE is an unconditional final branch.
          cond_s = top_s.parent && !top_s.taken &&
                   ((in_kind == K_ELSIF) ? def_q[in_sym] : 1'b1);
          if (depth_s == DPW'(0)) begin
            err_hit_s   = 1'b1;
            err_cause_s = ERR_UNDERFLOW;
          end else if (top_s.in_else) begin
            err_hit_s   = 1'b1;
            err_cause_s = ERR_ELSE_ORDER;
          end else begin
            wr_s     = 1'b1;
            din_s    = '{parent:  top_s.parent,
                         taken:   top_s.taken || cond_s || (in_kind == K_ELSE),
                         in_else: (in_kind == K_ELSE)};
            active_d = cond_s;
          end
        end
        K_ENDIF: begin
          if (depth_s == DPW'(0)) begin
            err_hit_s   = 1'b1;
            err_cause_s = ERR_UNDERFLOW;
          end else begin
            pop_s        = 1'b1;
            active_d     = top_s.parent;
            post_depth_s = depth_s - DPW'(1);
          end
        end
        K_DEFINE: begin
          if (active_q) begin
            def_d[in_sym] = 1'b1;
          end else begin
            def_d = def_q;
          end
        end
        K_UNDEF: begin
          if (active_q) begin
            def_d[in_sym] = 1'b0;
          end else begin
            def_d = def_q;
          end
        end
        default: begin
          def_d = def_q;
        end
      endcase

      if (!err_hit_s && in_last && (post_depth_s != DPW'(0))) begin
        err_hit_s   = 1'b1;
        err_cause_s = ERR_UNTERMINATED;
      end else begin
        err_cause_s = err_cause_s;
      end

      // An erroring token is cancelled entirely, including any TEXT forward.
      if (err_hit_s) begin
        active_d    = active_q;
        def_d       = def_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        wr_s        = 1'b0;
        state_d     = ST_ERR;
        err_d       = 1'b1;
        err_code_d  = err_cause_s;
      end else if (in_last) begin
        done_d = 1'b1;
      end else begin
        done_d = 1'b0;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      active_q    <= 1'b1;
      def_q       <= DEF_INIT;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      def_q       <= def_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

endmodule

// File: tb/tb_ifdef_stack_ctrl.sv
// Scoreboard bench for ifdef_stack_ctrl: stimulus pushes expected TEXT payloads,
// a monitor pops and compares every output handshake.
module tb_ifdef_stack_ctrl;
  import ifdef_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [3:0]  in_sym;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  depth;
  logic        active;
  logic        done;
  logic        err;
  logic [2:0]  err_code;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  ifdef_stack_ctrl #(.DEPTH(8), .SYMW(4), .DW(32), .DEF_INIT(16'h0008)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_sym(in_sym),
    .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .depth(depth), .active(active), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake must match the head of the scoreboard.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_out: got %0h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            fails++;
            $display("FAIL out_data: got %0h expected %0h", out_data, e);
          end
        end
      end
    end
  end

  task automatic wait_accept();
    bit ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send(input kind_e k, input logic [3:0] s, input logic [31:0] d, input logic l);
    in_valid = 1'b1;
    in_kind  = k;
    in_sym   = s;
    in_data  = d;
    in_last  = l;
    wait_accept();
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 20; n++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    repeat (3) @(posedge clk);
    #1;
    chk(name, exp_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_kind = 3'd0; in_sym = 4'd0; in_data = 32'd0; in_last = 1'b0;
    out_ready = 1'b1;
    do_reset();
    chk("rst_depth", depth, 32'd0);
    chk("rst_active", active, 32'd1);
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_done", done, 32'd0);
    chk("rst_err", err, 32'd0);
    chk("rst_err_code", err_code, 32'd0);

    // IFDEF 3 (defined) / ELSE: only A
    exp_q.push_back(32'hA);
    send(K_IFDEF, 4'd3, 32'd0, 1'b0);
    chk("ifdef3_depth", depth, 32'd1);
    send(K_TEXT, 4'd0, 32'hA, 1'b0);
    send(K_ELSE, 4'd0, 32'd0, 1'b0);
    chk("else_active", active, 32'd0);
    send(K_TEXT, 4'd0, 32'hB, 1'b0);
    send(K_ENDIF, 4'd0, 32'd0, 1'b1);
    chk("t1_done", done, 32'd1);
    chk("t1_depth", depth, 32'd0);
    chk("t1_active", active, 32'd1);
    @(posedge clk); #1;
    chk("t1_done_pulse", done, 32'd0);
    drain("t1_drain");

    // ELSIF chain: only C
    exp_q.push_back(32'hC);
    send(K_IFDEF, 4'd1, 32'd0, 1'b0);
    chk("ifdef1_active", active, 32'd0);
    send(K_ELSIF, 4'd2, 32'd0, 1'b0);
    chk("elsif2_active", active, 32'd0);
    send(K_ELSIF, 4'd3, 32'd0, 1'b0);
    chk("elsif3_active", active, 32'd1);
    send(K_TEXT, 4'd0, 32'hC, 1'b0);
    send(K_ELSE, 4'd0, 32'd0, 1'b0);
    chk("else_after_taken", active, 32'd0);
    send(K_TEXT, 4'd0, 32'hD, 1'b0);
    send(K_ENDIF, 4'd0, 32'd0, 1'b0);
    drain("t2_drain");

    // DEFINE in inactive branch has no effect; active DEFINE/UNDEF do
    send(K_IFDEF, 4'd1, 32'd0, 1'b0);
    send(K_DEFINE, 4'd5, 32'd0, 1'b0);
    send(K_ENDIF, 4'd0, 32'd0, 1'b0);
    send(K_IFDEF, 4'd5, 32'd0, 1'b0);
    chk("ifdef5_active", active, 32'd0);
    send(K_TEXT, 4'd0, 32'hE, 1'b0);
    send(K_ENDIF, 4'd0, 32'd0, 1'b0);
    exp_q.push_back(32'hF);
    exp_q.push_back(32'h6);
    send(K_DEFINE, 4'd6, 32'd0, 1'b0);
    send(K_IFDEF, 4'd6, 32'd0, 1'b0);
    send(K_TEXT, 4'd0, 32'hF, 1'b0);
    send(K_ENDIF, 4'd0, 32'd0, 1'b0);
    send(K_UNDEF, 4'd6, 32'd0, 1'b0);
    send(K_IFNDEF, 4'd6, 32'd0, 1'b0);
    send(K_TEXT, 4'd0, 32'h6, 1'b0);
    send(K_ENDIF, 4'd0, 32'd0, 1'b0);
    drain("t3_drain");

    // Overflow on ninth nested IFDEF
    do_reset();
    for (int i = 0; i < 8; i++) send(K_IFDEF, 4'd3, 32'd0, 1'b0);
    chk("full_depth", depth, 32'd8);
    chk("full_err", err, 32'd0);
    send(K_IFDEF, 4'd3, 32'd0, 1'b0);
    chk("ovf_err", err, 32'd1);
    chk("ovf_code", err_code, 32'd1);
    chk("ovf_depth", depth, 32'd8);
    chk("ovf_in_ready", in_ready, 32'd1);
    send(K_TEXT, 4'd0, 32'h99, 1'b0);
    send(K_ENDIF, 4'd0, 32'd0, 1'b1);
    chk("ovf_no_done", done, 32'd0);
    drain("ovf_drain");
    chk("ovf_out_valid", out_valid, 32'd0);
    chk("ovf_code_sticky", err_code, 32'd1);

    // Underflow
    do_reset();
    send(K_ENDIF, 4'd0, 32'd0, 1'b0);
    chk("unf_err", err, 32'd1);
    chk("unf_code", err_code, 32'd2);

    // Double ELSE; later underflow must not overwrite the first cause
    do_reset();
    send(K_IFDEF, 4'd3, 32'd0, 1'b0);
    send(K_ELSE, 4'd0, 32'd0, 1'b0);
    chk("else1_err", err, 32'd0);
    send(K_ELSE, 4'd0, 32'd0, 1'b0);
    chk("else_order_code", err_code, 32'd3);
    send(K_ENDIF, 4'd0, 32'd0, 1'b0);
    send(K_ENDIF, 4'd0, 32'd0, 1'b0);
    chk("else_order_sticky", err_code, 32'd3);

    // in_last at depth 2: unterminated, its TEXT is not forwarded
    do_reset();
    send(K_IFDEF, 4'd3, 32'd0, 1'b0);
    send(K_IFDEF, 4'd3, 32'd0, 1'b0);
    send(K_TEXT, 4'd0, 32'h77, 1'b1);
    chk("unterm_code", err_code, 32'd4);
    chk("unterm_done", done, 32'd0);
    chk("unterm_depth", depth, 32'd2);
    drain("unterm_drain");

    // Backpressure: second TEXT stalls, first output stays stable
    do_reset();
    out_ready = 1'b0;
    exp_q.push_back(32'h1111);
    send(K_TEXT, 4'd0, 32'h1111, 1'b0);
    exp_q.push_back(32'h2222);
    in_valid = 1'b1; in_kind = K_TEXT; in_sym = 4'd0; in_data = 32'h2222; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 32'd0);
      chk("bp_out_valid", out_valid, 32'd1);
      chk("bp_out_data", out_data, 32'h1111);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_accept();
    exp_q.push_back(32'h3333);
    send(K_TEXT, 4'd0, 32'h3333, 1'b1);
    chk("bp_done", done, 32'd1);
    @(posedge clk); #1;
    chk("bp_done_pulse", done, 32'd0);
    drain("bp_drain");

    // Reset mid-stream discards stack and pending output
    send(K_IFDEF, 4'd3, 32'd0, 1'b0);
    out_ready = 1'b0;
    send(K_TEXT, 4'd0, 32'h4444, 1'b0);
    do_reset();
    chk("mid_rst_out_valid", out_valid, 32'd0);
    chk("mid_rst_depth", depth, 32'd0);
    chk("mid_rst_active", active, 32'd1);
    out_ready = 1'b1;
    drain("mid_rst_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ifdef_stack_ctrl.md
IFDEF_STACK_CTRL -- requirements
Module: ifdef_stack_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  - DEPTH, 8, max conditional nesting levels.
  - SYMW, 4, macro symbol id width (2**SYMW symbols).
  - DW, 32, text payload width.
  - DEF_INIT, '0, reset value of the defined-symbol bitmap.
REQ-002 Ports (name, direction, width, meaning), one per line:
  - clk, in, 1, sole clock.
  - rst_n, in, 1, synchronous active-low reset.
  - in_valid, in, 1, input token valid.
  - in_ready, out, 1, input token accepted when in_valid && in_ready.
  - in_kind, in, 3, token kind (ifdef_pkg::kind_e).
  - in_sym, in, SYMW, symbol id for IFDEF/IFNDEF/ELSIF/DEFINE/UNDEF.
  - in_data, in, DW, text payload.
  - in_last, in, 1, final token of stream.
  - out_valid, out, 1, forwarded text valid.
  - out_ready, in, 1, downstream accepts.
  - out_data, out, DW, forwarded payload.
  - depth, out, $clog2(DEPTH+1), current nesting depth.
  - active, out, 1, current region is emitting.
  - done, out, 1, one-cycle pulse on clean end of stream.
  - err, out, 1, sticky error flag.
  - err_code, out, 3, first error cause (ifdef_pkg::err_e).

Function
REQ-003 kind_e values: TEXT=0, IFDEF=1, IFNDEF=2, ELSIF=3, ELSE=4, ENDIF=5, DEFINE=6, UNDEF=7.
REQ-004 in_ready SHALL be !out_valid || out_ready in state RUN and 1 in state ERR.
REQ-005 Accepted TEXT SHALL appear on out_data with out_valid exactly one cycle later when active=1, and SHALL be dropped when active=0.
REQ-006 Directive tokens SHALL never be forwarded; each SHALL update state in its accept cycle, visible to the next token.
REQ-007 Each stack entry SHALL hold {parent, taken, in_else}.
REQ-008 IFDEF/IFNDEF SHALL push {parent=active, taken=c, in_else=0} and set active=c, where c = active && def[sym] (IFNDEF: active && !def[sym]).
REQ-009 ELSIF SHALL set active = parent && !taken && def[sym], then taken |= active.
REQ-010 ELSE SHALL set active = parent && !taken, taken=1, in_else=1.
REQ-011 ENDIF SHALL set active=parent and pop.
REQ-012 DEFINE/UNDEF SHALL set/clear def[sym] only when active=1; otherwise no effect.
REQ-013 FSM states RUN and ERR; RUN->ERR on first error; ERR exits only by reset.
REQ-014 Errors, with err_code latched from the first occurrence only:
  - OVERFLOW=1: IFDEF/IFNDEF at depth==DEPTH.
  - UNDERFLOW=2: ELSIF/ELSE/ENDIF at depth 0.
  - ELSE_ORDER=3: ELSIF/ELSE with in_else=1.
  - UNTERMINATED=4: in_last accepted with post-token depth != 0.
  - The erroring token SHALL have no state effect.
REQ-015 In ERR, all tokens SHALL be consumed and dropped; out_valid drains, then stays 0.
REQ-016 in_last accepted with post-token depth 0 SHALL pulse done for 1 cycle; state stays RUN.
REQ-017 A token accepted while out_valid && !out_ready is impossible by REQ-004; out_data SHALL hold stable while out_valid && !out_ready.

Reset
REQ-018 Synchronous on rst_n=0: depth=0, active=1, def=DEF_INIT, out_valid=0, out_data=0, done=0, err=0, err_code=0 (NONE), state=RUN.
REQ-019 Reset mid-stream SHALL discard stack contents and any pending output.

Structure
REQ-020 Package ifdef_pkg SHALL hold kind_e, err_e, and the stack-entry struct.
REQ-021 Stack storage SHALL be a sub-module cond_stack (push/pop/top, DEPTH entries, registered).

Verification
REQ-022 DEF_INIT bit 3 set; IFDEF 3, TEXT A, ELSE, TEXT B, ENDIF -> only A emitted; depth returns to 0.
REQ-023 IFDEF 1 (undefined), ELSIF 2 (undefined), ELSIF 3 (defined), TEXT C, ELSE, TEXT D, ENDIF -> only C emitted.
REQ-024 DEFINE 5 inside an inactive branch, then IFDEF 5, TEXT E, ENDIF -> E dropped (5 not defined).
REQ-025 Nine nested IFDEF with DEPTH=8 -> err=1, err_code=OVERFLOW, in_ready=1, no further output.
REQ-026 ENDIF at depth 0 -> UNDERFLOW; separately ELSE, ELSE -> ELSE_ORDER; in_last at depth 2 -> UNTERMINATED.
REQ-027 out_ready held 0 for 5 cycles with TEXT pending -> in_ready=0 and out_data stable; clean in_last at depth 0 -> done one cycle.
